wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  execute result/load request offered.
REQ-006 SHALL have port in_ready  output  1  stage accepts offer this cycle.
REQ-007 SHALL have port in_rd  input  ADDR_WIDTH  destination register.
REQ-008 SHALL have port in_wen  input  1  instruction writes rd.
REQ-009 SHALL have port in_is_load  input  1  instruction is a load.
REQ-010 SHALL have port in_funct3  input  3  load size/sign code.
REQ-011 SHALL have port in_result  input  DATA_WIDTH  ALU result, or load byte address.
REQ-012 SHALL have port mem_rdata_valid  input  1  load data returned.
REQ-013 SHALL have port mem_rdata  input  DATA_WIDTH  raw aligned memory word.
REQ-014 SHALL have port mem_rdata_ready  output  1  stage accepts load data.
REQ-015 SHALL have ports rf_wen, rf_waddr, rf_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  register-file write port.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, WAIT_MEM, WRITE; in_ready=1 only in IDLE; mem_rdata_ready=1 only in WAIT_MEM.
REQ-018 IDLE with in_valid SHALL capture rd, wen, funct3, in_result[1:0], in_result; non-load -> WRITE, load -> WAIT_MEM.
REQ-019 WAIT_MEM with mem_rdata_valid SHALL capture extracted load data -> WRITE; otherwise hold indefinitely.
REQ-020 WRITE SHALL last exactly one cycle, then -> IDLE; no input accepted in WRITE.
REQ-021 rf_wen SHALL be registered, high only during WRITE, and only when captured wen=1 and rd!=0.
REQ-022 rf_waddr/rf_wdata SHALL hold captured values during WRITE; zero otherwise.
REQ-023 Latency: non-load accepted at edge N -> rf_wen high in cycle N+1; load data accepted at edge M -> rf_wen high in cycle M+1.
REQ-024 Load extraction by funct3: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW full word; 100 LBU, 101 LHU zero-extend; 011/110/111 write 0.
REQ-025 LH/LHU with addr[0]=1 SHALL ignore addr[0] (half selected by addr[1] only).
REQ-026 mem_rdata_valid outside WAIT_MEM SHALL be ignored with no state change.

Reset
REQ-027 rst assertion SHALL immediately force IDLE, rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, all captured fields 0.
REQ-028 rst mid-load or mid-WRITE SHALL abandon the instruction; no register write occurs.
REQ-029 After rst deassert, in_ready=1 in first cycle.

Configuration
REQ-030 With WB_FWD_EN defined, ports fwd_pending (1), fwd_rd (ADDR_WIDTH), fwd_data_valid (1), fwd_data (DATA_WIDTH) SHALL exist.
REQ-031 fwd_pending=1 when state!=IDLE and captured wen=1 and rd!=0; fwd_rd=captured rd; fwd_data_valid=1 only in WRITE; fwd_data=rf_wdata.
REQ-032 Without WB_FWD_EN, these ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package wb_pkg SHALL hold the state enum and funct3 load-code constants.
REQ-034 Combinational sub-module load_align (funct3, addr[1:0], word -> extended data) SHALL perform REQ-024/025.

Verification
REQ-035 ALU: in_valid, rd=5, wen=1, result=0x1234_5678 -> next cycle rf_wen=1, waddr=5, wdata=0x1234_5678, then IDLE.
REQ-036 LB addr=0x...3, mem_rdata=0x80FF_0000 after 3 wait cycles -> wdata=0xFFFF_FF80; busy high all 5 cycles.
REQ-037 LHU addr[1]=1, mem_rdata=0xBEEF_0000 -> wdata=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-038 rd=0, wen=1 -> rf_wen stays 0; with WB_FWD_EN fwd_pending stays 0.
REQ-039 rst asserted in WAIT_MEM, then mem_rdata_valid -> no rf_wen, state IDLE, in_ready=1.
REQ-040 Back-to-back in_valid held high: accepts every second cycle for ALU ops; stray mem_rdata_valid in IDLE ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback stage state encoding and load funct3 codes
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the loaded byte/half/word from an aligned memory word
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Halfword loads ignore addr[0]; misaligned halves read the containing half.
        half_sel = addr[1] ? word[31:16] : word[15:0];

        data = '0;
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: ALU results and load returns to the register file; WB_FWD_EN adds forwarding ports
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rdata_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_pending,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic                  fwd_data_valid,
    output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [DATA_WIDTH-1:0] load_data;

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .funct3(funct3_q),
        .addr  (addr_q),
        .word  (mem_rdata),
        .data  (load_data)
    );

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_d     = in_rd;
                    wen_d    = in_wen;
                    funct3_d = in_funct3;
                    addr_d   = in_result[1:0];
                    result_d = in_result;
                    state_d  = in_is_load ? ST_WAIT_MEM : ST_WRITE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rdata_valid) begin
                    result_d = load_data;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Write-port outputs are registered, so they are computed from the state being entered.
        rf_wen_d   = (state_d == ST_WRITE) && wen_d && (rd_d != '0);
        rf_waddr_d = (state_d == ST_WRITE) ? rd_d : '0;
        rf_wdata_d = (state_d == ST_WRITE) ? result_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            result_q   <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            result_q   <= result_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign in_ready        = (state_q == ST_IDLE);
    assign mem_rdata_ready = (state_q == ST_WAIT_MEM);
    assign busy            = (state_q != ST_IDLE);
    assign rf_wen          = rf_wen_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;

`ifdef WB_FWD_EN
    assign fwd_pending    = (state_q != ST_IDLE) && wen_q && (rd_q != '0);
    assign fwd_rd         = rd_q;
    assign fwd_data_valid = (state_q == ST_WRITE);
    assign fwd_data       = rf_wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage against a transaction-level model
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_result = '0;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdata_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
`ifdef WB_FWD_EN
    logic        fwd_pending;
    logic [4:0]  fwd_rd;
    logic        fwd_data_valid;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_result      (in_result),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .mem_rdata_ready(mem_rdata_ready),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy)
`ifdef WB_FWD_EN
        ,
        .fwd_pending    (fwd_pending),
        .fwd_rd         (fwd_rd),
        .fwd_data_valid (fwd_data_valid),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result from the architectural rules, using shifts and signed arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        longint v;
        int     ai;
        ai = int'(a);
        case (f3)
            3'd0: begin v = longint'((w >> (8 * ai)) & 32'hFF);            if (v > 127)   v = v - 256;   end
            3'd1: begin v = longint'((w >> (16 * (ai / 2))) & 32'hFFFF);   if (v > 32767) v = v - 65536; end
            3'd2: v = longint'(w);
            3'd4: v = longint'((w >> (8 * ai)) & 32'hFF);
            3'd5: v = longint'((w >> (16 * (ai / 2))) & 32'hFFFF);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_rf_wen"}, rf_wen, 0);
        check_eq({tag, "_waddr"}, rf_waddr, 0);
        check_eq({tag, "_wdata"}, rf_wdata, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_mem_ready"}, mem_rdata_ready, 0);
`ifdef WB_FWD_EN
        check_eq({tag, "_fwd_pending"}, fwd_pending, 0);
        check_eq({tag, "_fwd_dvalid"}, fwd_data_valid, 0);
`endif
    endtask

    task automatic scramble_inputs();
        in_rd      = 5'($urandom);
        in_wen     = 1'($urandom);
        in_is_load = 1'($urandom);
        in_funct3  = 3'($urandom);
        in_result  = $urandom;
        mem_rdata  = $urandom;
    endtask

    // One full instruction from IDLE back to IDLE; junk drives offers the stage must ignore.
    task automatic run_txn(input logic [4:0] rd, input logic wen, input logic is_load,
                           input logic [2:0] f3, input logic [31:0] res, input logic [31:0] word,
                           input int waits, input logic junk);
        logic [31:0] exp_data;
        logic        exp_wen;
        exp_data = is_load ? ref_load(f3, res[1:0], word) : res;
        exp_wen  = wen && (rd != 5'd0);

        check_eq("accept_ready", in_ready, 1);
        in_valid = 1'b1; in_rd = rd; in_wen = wen; in_is_load = is_load;
        in_funct3 = f3; in_result = res;
        mem_rdata_valid = junk; mem_rdata = $urandom;
        tick();
        in_valid = 1'b0; mem_rdata_valid = 1'b0;
        scramble_inputs();

        if (is_load) begin
            for (int i = 0; i <= waits; i++) begin
                check_eq("wait_busy", busy, 1);
                check_eq("wait_mem_ready", mem_rdata_ready, 1);
                check_eq("wait_in_ready", in_ready, 0);
                check_eq("wait_rf_wen", rf_wen, 0);
`ifdef WB_FWD_EN
                check_eq("wait_fwd_pending", fwd_pending, exp_wen);
                check_eq("wait_fwd_dvalid", fwd_data_valid, 0);
`endif
                in_valid = junk;
                if (i == waits) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = word;
                end
                tick();
                mem_rdata_valid = 1'b0;
                in_valid = 1'b0;
                scramble_inputs();
            end
        end

        check_eq("write_rf_wen", rf_wen, exp_wen);
        check_eq("write_waddr", rf_waddr, rd);
        check_eq("write_wdata", rf_wdata, exp_data);
        check_eq("write_busy", busy, 1);
        check_eq("write_in_ready", in_ready, 0);
        check_eq("write_mem_ready", mem_rdata_ready, 0);
`ifdef WB_FWD_EN
        check_eq("write_fwd_pending", fwd_pending, exp_wen);
        check_eq("write_fwd_rd", fwd_rd, rd);
        check_eq("write_fwd_dvalid", fwd_data_valid, 1);
        check_eq("write_fwd_data", fwd_data, exp_data);
`endif
        in_valid = junk;
        mem_rdata_valid = junk;
        tick();
        in_valid = 1'b0;
        mem_rdata_valid = 1'b0;
        check_idle("after_write");
    endtask

    initial begin
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_reset_in_ready", in_ready, 1);
        tick();

        run_txn(5'd5, 1'b1, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 0, 1'b0);
        run_txn(5'd7, 1'b1, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_0000, 3, 1'b0);
        run_txn(5'd9, 1'b1, 1'b1, 3'b101, 32'h0000_2002, 32'hBEEF_0000, 1, 1'b1);
        run_txn(5'd9, 1'b1, 1'b1, 3'b001, 32'h0000_2003, 32'hBEEF_0000, 0, 1'b1);
        run_txn(5'd0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        run_txn(5'd0, 1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 2, 1'b0);
        run_txn(5'd12, 1'b1, 1'b1, 3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b0);

        // Reset while waiting for load data abandons the load.
        in_valid = 1'b1; in_rd = 5'd3; in_wen = 1'b1; in_is_load = 1'b1;
        in_funct3 = 3'b010; in_result = 32'h100;
        tick();
        in_valid = 1'b0;
        check_eq("rst_wait_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_wait_busy_async", busy, 0);
        check_eq("rst_wait_in_ready_async", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rdata_valid = 1'b0;
        check_idle("rst_wait_after");

        // Reset during WRITE clears the write port immediately.
        in_valid = 1'b1; in_rd = 5'd4; in_wen = 1'b1; in_is_load = 1'b0; in_result = 32'h0BAD_F00D;
        tick();
        in_valid = 1'b0;
        check_eq("rst_write_rf_wen_before", rf_wen, 1);
        #2 rst = 1'b1;
        #1;
        check_idle("rst_write_async");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("rst_write_after");

        // Offer held high: ALU ops accepted every second cycle, stray load data ignored.
        in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_rd = 5'd21;
        mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b_in_ready", in_ready, (k % 2) == 0);
            check_eq("b2b_rf_wen", rf_wen, (k % 2) == 1);
            if ((k % 2) == 1) check_eq("b2b_wdata", rf_wdata, 32'hA000_0000 + 32'(k - 1));
            else in_result = 32'hA000_0000 + 32'(k);
            tick();
        end
        in_valid = 1'b0; mem_rdata_valid = 1'b0;
        check_idle("b2b_end");

        for (int n = 0; n < 40; n++) begin
            run_txn(5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
